sdu_hex_tx: RTL and testbench

- Transmit-side serializer for the serial debug unit's host link.
- Accepts 32-bit words (pc, IR, register or memory dumps) over a valid/ready handshake.
- Renders each word as 8 uppercase ASCII hex characters plus a separator.
- Shifts the characters out on txd as 8N1 UART frames. It is the output-direction counterpart of the rxd command path.

---
 rtl/sdu_hex_tx.sv | 172 +++++++++++++++++
 tb/tb_sdu_hex_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdu_hex_tx.sv
// sdu_hex_tx: transmit side of the serial debug unit host link.
// Accepts a 32-bit word over valid/ready and prints it on txd as eight
// uppercase ASCII hex characters followed by a space or CR LF.
// Each character is sent as an 8N1 UART frame, DIV clock cycles per bit.
// txd is registered, so the line never glitches while the character mux
// settles.
module sdu_hex_tx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        txd,
  output logic        busy
);

  // Clock cycles per UART bit. The design relies on DIV >= 2 so that the
  // baud counter is at least one bit wide.
  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  // Index of the last character: 8 for "XXXXXXXX ", 9 for "XXXXXXXX\r\n".
  localparam logic [3:0] LAST_IDX_SPACE = 4'd8;
  localparam logic [3:0] LAST_IDX_CRLF  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       char_idx_q, char_idx_d;
  logic [31:0]      word_q, word_d;
  logic             last_q, last_d;
  logic             txd_q, txd_d;

  logic             accept;
  logic             bit_end;
  logic             chars_done;
  logic [7:0]       tx_char;

  // ASCII for one hex nibble, uppercase letters.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

  // Character at position idx of the rendered word: nibbles MSB first,
  // then the separator.
  function automatic logic [7:0] char_at(input logic [31:0] w,
                                         input logic        l,
                                         input logic [3:0]  idx);
    logic [4:0] shamt;
    logic [3:0] nib;
    shamt = {3'd7 - idx[2:0], 2'b00};
    nib   = 4'(w >> shamt);
    if (idx < 4'd8) begin
      return hex_ascii(nib);
    end else if (idx == 4'd8) begin
      return l ? 8'h0D : 8'h20;
    end
    return 8'h0A;
  endfunction

  assign accept     = word_valid && (state_q == IDLE);
  assign bit_end    = (baud_q == BAUD_LAST);
  assign chars_done = (char_idx_q == (last_q ? LAST_IDX_CRLF : LAST_IDX_SPACE));

  // FSM state register; reset drops any frame in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start bit, 8 data bits, stop bit, repeat per character.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise untouched paths would infer latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)  state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_end) state_d = chars_done ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: counters, latched word and the registered line.
  // NOTE: the word latch is reset too, so a reset mid-frame really discards
  // the word rather than leaving stale data that only the FSM ignores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q     <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      txd_q      <= txd_d;
    end
  end

  // Counter and capture updates. IDLE keeps the counters cleared so every
  // word starts from character 0, bit 0; the bit index wraps 7 -> 0 on
  // leaving DATA, ready for the next character.
  always_comb begin
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    word_d     = word_q;
    last_d     = last_q;
    if (state_q == IDLE) begin
      baud_d     = '0;
      bit_idx_d  = '0;
      char_idx_d = '0;
      if (accept) begin
        word_d = word_data;
        last_d = word_last;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) begin
        if (state_q == DATA) begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
        if ((state_q == STOP) && !chars_done) begin
          char_idx_d = char_idx_q + 4'd1;
        end
      end
    end
  end

  // Outputs. The line level is computed from the next state so the
  // registered txd changes on the same edge as the FSM.
  always_comb begin
    tx_char = char_at(word_d, last_d, char_idx_d);
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_char[bit_idx_d];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
    word_ready = (state_q == IDLE);
    busy       = (state_q != IDLE);
    txd        = txd_q;
  end

endmodule

// File: tb/tb_sdu_hex_tx.sv
// tb_sdu_hex_tx: directed bench for sdu_hex_tx at DIV = 4.
// Every clock of every frame is compared against the expected 8N1
// waveform of hand-listed ASCII bytes.
module tb_sdu_hex_tx;

  localparam int DIV = 4;
  localparam int SPC = 10 * DIV;   // samples per character

  logic        clk;
  logic        rst;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        word_last;
  logic        txd;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  sdu_hex_tx #(
    .CLK_FREQ(1000),
    .BAUD    (250)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data (word_data),
    .word_last (word_last),
    .txd       (txd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected txd per clock for one byte: start, d0..d7, stop, DIV each.
  function automatic logic [SPC-1:0] frame_of(input logic [7:0] b);
    logic [SPC-1:0] v;
    for (int i = 0; i < SPC; i++) begin
      int bp;
      bp = i / DIV;
      if (bp == 0)      v[i] = 1'b0;
      else if (bp == 9) v[i] = 1'b1;
      else              v[i] = b[bp-1];
    end
    return v;
  endfunction

  // Present a word at a falling edge; returns at the first falling edge
  // after the accepting rising edge (sample 0 of the first frame).
  task automatic drive_word(input logic [31:0] d, input logic l, input bit hold);
    @(negedge clk);
    n_vec++;
    if (word_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_before_accept: word_ready=%b, expected 1", word_ready);
    end
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    @(posedge clk);
    @(negedge clk);
    if (!hold) word_valid = 1'b0;
  endtask

  // Sample txd on every falling edge for nchar frames and compare each frame
  // as a whole. Optionally overwrite word_data/word_last at sample poke_at.
  // Returns at the falling edge right after the last stop bit.
  task automatic expect_word(input string       name,
                             input logic [7:0]  exp [10],
                             input int          nchar,
                             input int          poke_at,
                             input logic [31:0] poke_val);
    int k;
    int low_cycles;
    logic [SPC-1:0] obs;
    k = 0;
    low_cycles = 0;
    for (int c = 0; c < nchar; c++) begin
      for (int i = 0; i < SPC; i++) begin
        if (k == poke_at) begin
          word_data = poke_val;
          word_last = ~word_last;
        end
        obs[i] = txd;
        if ((word_ready === 1'b0) && (busy === 1'b1)) low_cycles++;
        k++;
        @(negedge clk);
      end
      n_vec++;
      if (obs !== frame_of(exp[c])) begin
        n_miss++;
        $display("FAIL %s char %0d: txd samples %h, expected %h (byte %h)",
                 name, c, obs, frame_of(exp[c]), exp[c]);
      end
    end
    n_vec++;
    if (low_cycles != SPC * nchar) begin
      n_miss++;
      $display("FAIL %s ready_low: %0d busy cycles, expected %0d",
               name, low_cycles, SPC * nchar);
    end
    n_vec++;
    if ({word_ready, busy, txd} !== 3'b101) begin
      n_miss++;
      $display("FAIL %s end_idle: ready/busy/txd=%b, expected 101",
               name, {word_ready, busy, txd});
    end
  endtask

  task automatic test_reset;
    rst        = 1'b0;
    word_valid = 1'b1;
    word_data  = 32'h0000_0001;
    word_last  = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({txd, word_ready, busy} !== 3'b110) begin
      n_miss++;
      $display("FAIL reset_immediate: txd/ready/busy=%b, expected 110",
               {txd, word_ready, busy});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({txd, word_ready, busy} !== 3'b110) begin
        n_miss++;
        $display("FAIL reset_hold cycle %0d: txd/ready/busy=%b, expected 110",
                 i, {txd, word_ready, busy});
      end
    end
    word_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({txd, word_ready, busy} !== 3'b110) begin
      n_miss++;
      $display("FAIL reset_release: txd/ready/busy=%b, expected 110",
               {txd, word_ready, busy});
    end
  endtask

  task automatic test_word_space;
    logic [7:0] e [10];
    e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20, 8'h00};
    drive_word(32'h1234_ABCD, 1'b0, 1'b0);
    expect_word("word_1234ABCD", e, 9, -1, 32'h0);
  endtask

  task automatic test_word_crlf;
    logic [7:0] e [10];
    e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    drive_word(32'hDEAD_BEEF, 1'b1, 1'b0);
    expect_word("word_DEADBEEF", e, 10, -1, 32'h0);
  endtask

  // valid stays high; the second word is presented while the first is
  // still on the line and must be taken after exactly one IDLE cycle.
  task automatic test_back_to_back;
    logic [7:0] e0 [10];
    logic [7:0] e1 [10];
    e0 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h00};
    e1 = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h20, 8'h00};
    drive_word(32'h0000_0000, 1'b0, 1'b1);
    word_data = 32'hFFFF_FFFF;
    expect_word("b2b_00000000", e0, 9, -1, 32'h0);
    @(negedge clk);
    word_valid = 1'b0;
    expect_word("b2b_FFFFFFFF", e1, 9, -1, 32'h0);
  endtask

  task automatic test_data_hold;
    logic [7:0] e [10];
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h20, 8'h00};
    drive_word(32'h0000_000F, 1'b0, 1'b0);
    expect_word("hold_0000000F", e, 9, 50, 32'h5555_5555);
    word_last = 1'b0;
  endtask

  // Reset while the third character ('3' = 0x33) is on data bit 3 (a 0).
  task automatic test_reset_mid_frame;
    logic [7:0] e [10];
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h39, 8'h20, 8'h00};
    drive_word(32'h1234_5678, 1'b0, 1'b0);
    repeat (2 * SPC + 4 * DIV) @(negedge clk);
    n_vec++;
    if ({txd, busy} !== 2'b01) begin
      n_miss++;
      $display("FAIL midframe_pre: txd/busy=%b, expected 01", {txd, busy});
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({txd, word_ready, busy} !== 3'b110) begin
      n_miss++;
      $display("FAIL midframe_reset: txd/ready/busy=%b, expected 110",
               {txd, word_ready, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({txd, word_ready, busy} !== 3'b110) begin
      n_miss++;
      $display("FAIL midframe_after: txd/ready/busy=%b, expected 110",
               {txd, word_ready, busy});
    end
    drive_word(32'h0000_0009, 1'b0, 1'b0);
    expect_word("after_reset_00000009", e, 9, -1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_word_space();
    test_word_crlf();
    test_back_to_back();
    test_data_hold();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
